// File: rtl/sat_solution_checker.sv
// Post-solve verifier: walks the clause table, looks up each literal's variable and
// reports SAT/UNSAT, the number of unsatisfied clauses and the first one found.
module sat_solution_checker #(
    parameter int NSAT          = 3,
    parameter int NUM_VARIABLES = 16,
    parameter int NUM_CLAUSES   = 64,
    parameter int VAR_IDX_W     = $clog2(NUM_VARIABLES + 1),
    parameter int LIT_W         = VAR_IDX_W + 1,
    parameter int CL_ADDR_W     = $clog2(NUM_CLAUSES)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [CL_ADDR_W:0]      num_clauses_i,
    output logic                    clause_rd_en_o,
    output logic [CL_ADDR_W-1:0]    clause_addr_o,
    input  logic [NSAT*LIT_W-1:0]   clause_data_i,
    output logic                    var_rd_en_o,
    output logic [VAR_IDX_W-1:0]    var_addr_o,
    input  logic                    var_data_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    sat_o,
    output logic [CL_ADDR_W:0]      unsat_count_o,
    output logic [CL_ADDR_W-1:0]    first_unsat_o
);

    localparam int LIT_SEL_W = (NSAT > 1) ? $clog2(NSAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CL_RD,
        CL_WAIT,
        LIT,
        VAR_WAIT,
        CL_END,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [CL_ADDR_W:0]      count;
    logic [CL_ADDR_W-1:0]    clause;
    logic [LIT_SEL_W-1:0]    lit;
    logic [NSAT*LIT_W-1:0]   clause_word;
    logic                    clause_true;
    logic [CL_ADDR_W:0]      unsat_count;
    logic [CL_ADDR_W-1:0]    first_unsat;
    logic                    sat;

    logic [LIT_W-1:0]        cur_lit;
    logic [VAR_IDX_W-1:0]    cur_idx;
    logic                    cur_neg;
    logic                    last_lit;
    logic                    last_clause;
    logic                    lit_true;

    assign cur_lit     = clause_word[int'(lit)*LIT_W +: LIT_W];
    assign cur_idx     = cur_lit[VAR_IDX_W-1:0];
    assign cur_neg     = cur_lit[LIT_W-1];
    assign last_lit    = (lit == LIT_SEL_W'(NSAT - 1));
    assign last_clause = (((CL_ADDR_W+1)'(clause) + 1'b1) == count);
    assign lit_true    = (var_data_i != cur_neg);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        clause_rd_en_o = 1'b0;
        clause_addr_o  = '0;
        var_rd_en_o    = 1'b0;
        var_addr_o     = '0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (num_clauses_i == '0) ? DONE : CL_RD;
                end
            end
            CL_RD: begin
                clause_rd_en_o = 1'b1;
                clause_addr_o  = clause;
                state_next     = CL_WAIT;
            end
            CL_WAIT: begin
                state_next = LIT;
            end
            LIT: begin
                if (cur_idx == '0) begin
                    state_next = last_lit ? CL_END : LIT;
                end else begin
                    var_rd_en_o = 1'b1;
                    var_addr_o  = cur_idx;
                    state_next  = VAR_WAIT;
                end
            end
            VAR_WAIT: begin
                // A true literal satisfies the clause; the rest are never read.
                if (lit_true || last_lit) begin
                    state_next = CL_END;
                end else begin
                    state_next = LIT;
                end
            end
            CL_END: begin
                state_next = last_clause ? DONE : CL_RD;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count       <= '0;
            clause      <= '0;
            lit         <= '0;
            clause_word <= '0;
            clause_true <= 1'b0;
            unsat_count <= '0;
            first_unsat <= '0;
            sat         <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        count       <= num_clauses_i;
                        clause      <= '0;
                        unsat_count <= '0;
                        first_unsat <= '0;
                        sat         <= 1'b1;
                    end
                end
                CL_WAIT: begin
                    clause_word <= clause_data_i;
                    lit         <= '0;
                    clause_true <= 1'b0;
                end
                LIT: begin
                    if (cur_idx == '0 && !last_lit) begin
                        lit <= lit + 1'b1;
                    end
                end
                VAR_WAIT: begin
                    if (lit_true) begin
                        clause_true <= 1'b1;
                    end else if (!last_lit) begin
                        lit <= lit + 1'b1;
                    end
                end
                CL_END: begin
                    // An all-empty clause leaves clause_true clear and counts as UNSAT.
                    if (!clause_true) begin
                        unsat_count <= unsat_count + 1'b1;
                        sat         <= 1'b0;
                        if (unsat_count == '0) begin
                            first_unsat <= clause;
                        end
                    end
                    if (!last_clause) begin
                        clause <= clause + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o        = (state != IDLE) && (state != DONE);
    assign done_o        = (state == DONE);
    assign sat_o         = sat;
    assign unsat_count_o = unsat_count;
    assign first_unsat_o = first_unsat;

endmodule

// File: tb/tb_sat_solution_checker.sv
// Scoreboard bench for sat_solution_checker: the driver queues hand-computed results,
// a negedge monitor pops and compares them whenever done_o pulses.
module tb_sat_solution_checker;

    localparam int NSAT      = 3;
    localparam int VAR_IDX_W = 5;
    localparam int LIT_W     = 6;
    localparam int CL_ADDR_W = 6;
    localparam int CW        = NSAT * LIT_W;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 start_i = 1'b0;
    logic [CL_ADDR_W:0]   num_clauses_i = '0;
    logic                 clause_rd_en_o;
    logic [CL_ADDR_W-1:0] clause_addr_o;
    logic [CW-1:0]        clause_data_i = '0;
    logic                 var_rd_en_o;
    logic [VAR_IDX_W-1:0] var_addr_o;
    logic                 var_data_i = 1'b0;
    logic                 busy_o;
    logic                 done_o;
    logic                 sat_o;
    logic [CL_ADDR_W:0]   unsat_count_o;
    logic [CL_ADDR_W-1:0] first_unsat_o;

    sat_solution_checker #(
        .NSAT(NSAT),
        .NUM_VARIABLES(16),
        .NUM_CLAUSES(64)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .start_i(start_i),
        .num_clauses_i(num_clauses_i),
        .clause_rd_en_o(clause_rd_en_o),
        .clause_addr_o(clause_addr_o),
        .clause_data_i(clause_data_i),
        .var_rd_en_o(var_rd_en_o),
        .var_addr_o(var_addr_o),
        .var_data_i(var_data_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .sat_o(sat_o),
        .unsat_count_o(unsat_count_o),
        .first_unsat_o(first_unsat_o)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] cmem [64];
    logic          vmem [17];

    always @(posedge clk) begin
        if (clause_rd_en_o) clause_data_i <= cmem[clause_addr_o];
        if (var_rd_en_o)    var_data_i    <= vmem[var_addr_o];
    end

    typedef struct {
        bit sat;
        int unsat;
        int first;
        int lat;
        int c0;
    } exp_t;

    exp_t exp_q[$];
    int   clause_log[$];
    int   var_log[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   checks = 0;
    int   failures = 0;
    bit   prev_rd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            prev_rd = 1'b0;
        end else begin
            if (clause_rd_en_o) clause_log.push_back(int'(clause_addr_o));
            if (var_rd_en_o)    var_log.push_back(int'(var_addr_o));
            if (clause_rd_en_o || var_rd_en_o) begin
                check("strobe_spacing", int'((clause_rd_en_o && var_rd_en_o) || prev_rd), 0);
            end
            prev_rd = clause_rd_en_o || var_rd_en_o;
            if (done_o) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sat", int'(sat_o), int'(e.sat));
                    check("unsat_count", int'(unsat_count_o), e.unsat);
                    check("first_unsat", int'(first_unsat_o), e.first);
                    check("latency", cyc - e.c0 + 1, e.lat);
                    check("busy_in_done", int'(busy_o), 0);
                end
            end
        end
    end

    function automatic logic [LIT_W-1:0] mk(input bit neg, input int idx);
        return {neg, VAR_IDX_W'(idx)};
    endfunction

    task automatic load_test2();
        vmem[1] = 1'b1;
        vmem[2] = 1'b0;
        cmem[0] = {mk(0, 0), mk(1, 2), mk(0, 1)};
        cmem[1] = {mk(0, 0), mk(0, 2), mk(1, 1)};
    endtask

    task automatic do_start(input int n, input bit es, input int eu, input int ef, input int el);
        @(negedge clk);
        clause_log.delete();
        var_log.delete();
        start_i = 1'b1;
        num_clauses_i = (CL_ADDR_W+1)'(n);
        exp_q.push_back('{es, eu, ef, el, cyc + 1});
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int base;
        bit seen;
        base = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_cnt != base) seen = 1'b1;
        end
        if (!seen) begin
            check(name, 0, 1);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_test2_reads(input string name);
        int expv[3];
        expv = '{1, 1, 2};
        check({name, "_var_reads_n"}, var_log.size(), 3);
        for (int i = 0; i < 3 && i < var_log.size(); i++) begin
            check({name, "_var_read"}, var_log[i], expv[i]);
        end
        check({name, "_clause_reads_n"}, clause_log.size(), 2);
    endtask

    initial begin
        int bad;
        bit seen;
        int base;
        for (int i = 0; i < 64; i++) cmem[i] = '0;
        for (int v = 0; v < 17; v++) vmem[v] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_sat", int'(sat_o), 1);
        check("rst_unsat", int'(unsat_count_o), 0);
        check("rst_first", int'(first_unsat_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_strobes", int'(clause_rd_en_o) + int'(var_rd_en_o), 0);
        rst_i = 1'b1;

        // Test 1: empty table.
        do_start(0, 1'b1, 0, 0, 1);
        wait_done("t1_timeout", 20);
        check("t1_clause_reads", clause_log.size(), 0);
        check("t1_var_reads", var_log.size(), 0);

        // Test 2: x1=1, x2=0; clause1 is unsatisfied.
        load_test2();
        do_start(2, 1'b0, 1, 1, 14);
        wait_done("t2_timeout", 100);
        check_test2_reads("t2");
        check("t2_hold_sat", int'(sat_o), 0);
        check("t2_hold_count", int'(unsat_count_o), 1);

        // Test 3: one all-empty clause.
        cmem[0] = '0;
        do_start(1, 1'b0, 1, 0, 7);
        wait_done("t3_timeout", 100);
        check("t3_var_reads", var_log.size(), 0);
        check("t3_clause_reads", clause_log.size(), 1);

        // Test 4: full table, lit0 of every clause is true.
        for (int v = 1; v <= 16; v++) vmem[v] = v[0];
        for (int i = 0; i < 64; i++) begin
            int v;
            v = (i % 16) + 1;
            cmem[i] = {mk(1, 3), mk(0, 4), mk(!v[0], v)};
        end
        do_start(64, 1'b1, 0, 0, 321);
        wait_done("t4_timeout", 1000);
        check("t4_clause_reads_n", clause_log.size(), 64);
        bad = 0;
        for (int i = 0; i < clause_log.size(); i++) begin
            if (clause_log[i] != i) bad++;
        end
        check("t4_addr_sweep", bad, 0);
        check("t4_var_reads_n", var_log.size(), 64);

        // Test 5: a second start while busy is ignored.
        load_test2();
        do_start(2, 1'b0, 1, 1, 14);
        repeat (3) @(negedge clk);
        start_i = 1'b1;
        num_clauses_i = 7'd5;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("t5_timeout", 100);
        check_test2_reads("t5");

        // Test 6: reset in a LIT cycle aborts the check.
        load_test2();
        do_start(2, 1'b0, 1, 1, 14);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (var_rd_en_o) seen = 1'b1;
            else @(negedge clk);
        end
        check("t6_found_lit", int'(seen), 1);
        base = done_cnt;
        rst_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t6_rst_strobes", int'(clause_rd_en_o) + int'(var_rd_en_o), 0);
        check("t6_rst_sat", int'(sat_o), 1);
        check("t6_rst_count", int'(unsat_count_o), 0);
        check("t6_rst_busy", int'(busy_o), 0);
        check("t6_rst_done", int'(done_o), 0);
        rst_i = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_done", done_cnt - base, 0);
        do_start(2, 1'b0, 1, 1, 14);
        wait_done("t6_timeout", 100);
        check_test2_reads("t6");

        check("leftover_expect", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
